// File: rtl/fir_out_requant.sv
// Output requantizer for the 6-tap FIR: warm-up discard, round/shift to WIDTH_OUT, small FIFO, valid/ready out.
// Optional saturation on narrowing is enabled by defining FIR_REQUANT_SAT_EN (default: two's-complement wrap).
module fir_out_requant #(
    parameter int WIDTH_IN  = 54,
    parameter int WIDTH_OUT = 18,
    parameter int SHIFT     = 8,
    parameter int LATENCY   = 7,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [WIDTH_IN-1:0]  din,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH_OUT-1:0] m_data,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          sat_cnt
);

    localparam int RW  = WIDTH_IN + 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WCW = $clog2(LATENCY + 1);

    localparam logic signed [RW-1:0] RND  = $signed(RW'(1) << (SHIFT - 1));
`ifdef FIR_REQUANT_SAT_EN
    localparam logic signed [RW-1:0] MAXV = $signed((RW'(1) << (WIDTH_OUT - 1)) - RW'(1));
    localparam logic signed [RW-1:0] MINV = $signed(-(RW'(1) << (WIDTH_OUT - 1)));

    function automatic logic signed [WIDTH_OUT-1:0] narrow(input logic signed [RW-1:0] v);
        if (v > MAXV)
            return {1'b0, {(WIDTH_OUT-1){1'b1}}};
        else if (v < MINV)
            return {1'b1, {(WIDTH_OUT-1){1'b0}}};
        else
            return v[WIDTH_OUT-1:0];
    endfunction

    function automatic logic clipped(input logic signed [RW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction
`else
    function automatic logic signed [WIDTH_OUT-1:0] narrow(input logic signed [WIDTH_OUT-1:0] v);
        return v;
    endfunction
`endif

    logic [WCW-1:0]              r_wcnt;
    logic                        r_s1_valid;
    logic signed [RW-1:0]        r_round_p0;
    logic signed [RW-1:0]        w_sum;
    logic signed [WIDTH_OUT-1:0] w_narrow;
    logic                        w_capture;

    logic signed [WIDTH_OUT-1:0] r_mem [DEPTH];
    logic [AW-1:0]               r_wptr;
    logic [AW-1:0]               r_rptr;
    logic [CW-1:0]               r_count;
    logic [15:0]                 r_drop_cnt;
    logic                        w_full;
    logic                        w_pop;
    logic                        w_we;
    logic                        w_drop;

    // Stage p0: warm-up gate and round-half-up with a guard bit
    assign w_capture = ena && (r_wcnt == WCW'(LATENCY));
    assign w_sum     = $signed({din[WIDTH_IN-1], din}) + RND;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt     <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            if (ena && (r_wcnt != WCW'(LATENCY)))
                r_wcnt <= r_wcnt + WCW'(1);
            r_s1_valid <= w_capture;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture)
            r_round_p0 <= w_sum >>> SHIFT;
    end

    // Stage p1: narrow and push into the FIFO
`ifdef FIR_REQUANT_SAT_EN
    logic [15:0] r_sat_cnt;

    assign w_narrow = narrow(r_round_p0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_sat_cnt <= '0;
        else if (r_s1_valid && clipped(r_round_p0) && (r_sat_cnt != 16'hFFFF))
            r_sat_cnt <= r_sat_cnt + 16'd1;
    end

    assign sat_cnt = r_sat_cnt;
`else
    logic w_unused_hi;

    assign w_narrow    = narrow(r_round_p0[WIDTH_OUT-1:0]);
    assign w_unused_hi = ^r_round_p0[RW-1:WIDTH_OUT];
    assign sat_cnt     = '0;
`endif

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = m_valid && m_ready;
    assign w_we   = r_s1_valid && (!w_full || w_pop);
    assign w_drop = r_s1_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[r_wptr] <= w_narrow;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_we)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_we, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    // Head is gated so an empty FIFO presents zero rather than stale storage.
    assign m_valid  = (r_count != '0);
    assign m_data   = m_valid ? r_mem[r_rptr] : '0;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: warm-up, rounding, narrowing, FIFO full/drop, async reset flush.
module tb_fir_out_requant;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [53:0] din;
    logic        m_valid;
    logic        m_ready;
    logic [17:0] m_data;
    logic [15:0] drop_cnt;
    logic [15:0] sat_cnt;

    int n_vec;
    int n_err;

`ifdef FIR_REQUANT_SAT_EN
    localparam longint EXP_HI   = 131071;
    localparam longint EXP_LO   = -131072;
    localparam longint EXP_SAT2 = 2;
`else
    localparam longint EXP_HI   = 0;
    localparam longint EXP_LO   = 0;
    localparam longint EXP_SAT2 = 0;
`endif

    fir_out_requant dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .din      (din),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .drop_cnt (drop_cnt),
        .sat_cnt  (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b0;
        ena     = 1'b0;
        din     = '0;
        m_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_m_valid", longint'(m_valid), 0);
        chk("rst_m_data", longint'($signed(m_data)), 0);
        chk("rst_drop_cnt", longint'(drop_cnt), 0);
        chk("rst_sat_cnt", longint'(sat_cnt), 0);
        chk("rst_wcnt", longint'(dut.r_wcnt), 0);

        // Warm-up: 7 ena cycles are discarded
        rst = 1'b1;
        tick();
        ena = 1'b1;
        din = 54'(1000);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("warm_m_valid_%0d", i), longint'(m_valid), 0);
        end
        chk("warm_wcnt", longint'(dut.r_wcnt), 7);
        chk("warm_count", longint'(dut.r_count), 0);

        // Rounding: 511 -> 2, -384 -> -1
        m_ready = 1'b1;
        din = 54'(511);
        tick();
        chk("rnd_a_not_yet", longint'(m_valid), 0);
        din = -54'(384);
        tick();
        chk("rnd_a_valid", longint'(m_valid), 1);
        chk("rnd_a_data", longint'($signed(m_data)), 2);
        ena = 1'b0;
        tick();
        chk("rnd_b_valid", longint'(m_valid), 1);
        chk("rnd_b_data", longint'($signed(m_data)), -1);
        tick();
        chk("rnd_empty", longint'(m_valid), 0);

        // Narrowing of out-of-range values
        ena = 1'b1;
        din = 54'(1) << 40;
        tick();
        din = -(54'(1) << 40);
        tick();
        chk("sat_hi_data", longint'($signed(m_data)), EXP_HI);
        ena = 1'b0;
        tick();
        chk("sat_lo_data", longint'($signed(m_data)), EXP_LO);
        chk("sat_cnt", longint'(sat_cnt), EXP_SAT2);
        tick();
        chk("sat_empty", longint'(m_valid), 0);

        // Fill with m_ready=0: 1..4 kept, 5 and 6 dropped
        m_ready = 1'b0;
        ena = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            din = 54'(k * 256);
            tick();
        end
        ena = 1'b0;
        tick();
        chk("full_count", longint'(dut.r_count), 4);
        chk("full_drop", longint'(drop_cnt), 2);
        chk("full_head", longint'($signed(m_data)), 1);
        tick();
        chk("full_head_stable", longint'($signed(m_data)), 1);

        // Full with simultaneous push and pop
        ena = 1'b1;
        din = 54'(7 * 256);
        tick();
        ena = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("pp_drop", longint'(drop_cnt), 2);
        chk("pp_count", longint'(dut.r_count), 4);
        chk("pp_head", longint'($signed(m_data)), 2);
        tick();
        chk("drain_3", longint'($signed(m_data)), 3);
        tick();
        chk("drain_4", longint'($signed(m_data)), 4);
        tick();
        chk("drain_7", longint'($signed(m_data)), 7);
        tick();
        chk("drain_empty", longint'(m_valid), 0);

        // Queue 3 entries, then asynchronous reset mid-cycle
        m_ready = 1'b0;
        ena = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            din = 54'(k * 256);
            tick();
        end
        ena = 1'b0;
        tick();
        chk("pre_rst_count", longint'(dut.r_count), 3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_m_valid", longint'(m_valid), 0);
        chk("arst_drop", longint'(drop_cnt), 0);
        chk("arst_sat", longint'(sat_cnt), 0);
        chk("arst_wcnt", longint'(dut.r_wcnt), 0);
        tick();
        rst = 1'b1;
        ena = 1'b1;
        m_ready = 1'b1;
        din = 54'(9 * 256);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("rewarm_m_valid_%0d", i), longint'(m_valid), 0);
        end
        tick();
        chk("rewarm_cap_pending", longint'(m_valid), 0);
        ena = 1'b0;
        tick();
        chk("rewarm_valid", longint'(m_valid), 1);
        chk("rewarm_data", longint'($signed(m_data)), 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_out_requant.md
# fir_out_requant

Output stage placed directly downstream of the 6-tap FIR filter top. Consumes the filter's 54-bit signed accumulator output and discards samples still flushing through the tap chain after reset. Rounds and shifts each valid sample to 18 bits, then buffers the results in a small FIFO. Delivers samples on a valid/ready stream interface to the next consumer, with drop and saturation counters.

## Interface
- `WIDTH_IN`, 54, accumulator width from the filter
- `WIDTH_OUT`, 18, output sample width
- `SHIFT`, 8, right-shift applied before narrowing (≥1)
- `LATENCY`, 7, `ena` cycles from filter input to first meaningful `din`
- `DEPTH`, 4, FIFO entries (power of 2, ≥2)
- `clk` in 1 — rising-edge clock
- `rst` in 1 — reset, asynchronous, active-low
- `ena` in 1 — same enable that drives the filter; one sample per `ena` cycle
- `din` in `WIDTH_IN` — signed filter output
- `m_valid` out 1 — FIFO head valid
- `m_ready` in 1 — consumer accepts head
- `m_data` out `WIDTH_OUT` — signed FIFO head sample
- `drop_cnt` out 16 — samples lost to full FIFO, saturating
- `sat_cnt` out 16 — samples clipped by saturation, saturating

## Operation
- Warm-up counter `wcnt` (0..`LATENCY`):
  - Increments on each `ena` cycle until it equals `LATENCY`, then holds.
  - `din` is ignored while `wcnt` < `LATENCY`.
- Capture: on an edge with `ena`=1 and `wcnt`==`LATENCY`, register the rounded value `r` and set `s1_valid`. Otherwise clear `s1_valid`.
  - Rounding: `r = (din + 2^(SHIFT-1)) >>> SHIFT` (arithmetic), with one guard bit so the add cannot overflow.
- Narrowing: `r` is narrowed to `WIDTH_OUT` per the Configuration section.
- Push: when `s1_valid`=1, the narrowed value is written to the FIFO on the next edge.
- Pop: `m_valid && m_ready` at an edge removes the head.
- FIFO full and push without pop:
  - The sample is dropped and `drop_cnt` increments (holds at 0xFFFF).
  - FIFO contents are unchanged.
- FIFO full with simultaneous push and pop: both occur; occupancy is unchanged and nothing is dropped.
- FIFO empty with push: `m_valid` rises after that edge; there is no fall-through in the same cycle.
- Read/write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. Occupancy uses a separate `log2(DEPTH)+1`-bit count.
- `m_data` is the registered head entry and is stable while `m_valid`=1 and `m_ready`=0.

## Timing
- Reset (`rst`=0, asynchronous), all cleared:
  - `m_valid`=0, `m_data`=0
  - `drop_cnt`=0, `sat_cnt`=0
  - `wcnt`=0, `s1_valid`=0
  - FIFO pointers and count = 0
- Reset asserted mid-operation flushes the FIFO and restarts warm-up; the first `LATENCY` `ena` cycles after release are discarded again.
- Release is taken at the first rising edge with `rst`=1.
- Latency: `din` captured at edge N → FIFO write at edge N+1 → `m_valid`=1 during the cycle after edge N+1 (FIFO previously empty).
- `sat_cnt` updates at the same edge as the FIFO write, including when that sample is dropped.
- Throughput: 1 sample per clock when `ena`=1 continuously and `m_ready`=1.

## Configuration
- `FIR_REQUANT_SAT_EN`, defined:
  - `r` above 2^(`WIDTH_OUT`-1)-1 clamps to 131071; `r` below -2^(`WIDTH_OUT`-1) clamps to -131072.
  - Each clamp increments `sat_cnt`.
- Not defined:
  - `r` is truncated to its low `WIDTH_OUT` bits (two's-complement wrap).
  - `sat_cnt` is tied to 0 and no comparators are built.

## Test plan
- Reset then `ena`=1 for 7 cycles with `din`=1000 → no FIFO write; `m_valid` stays 0; `wcnt`=7.
- After warm-up, `din`=511 then `din`=-384, `m_ready`=1 → `m_data`=2 then -1; each `m_valid` appears 2 edges after its capture.
- `SAT_EN` defined, `din`=2^40 then `din`=-2^40 → `m_data`=131071 then -131072; `sat_cnt`=2.
  - Undefined: `m_data`=0 for both, `sat_cnt`=0.
- `m_ready`=0 with 6 valid samples (`din`=256·k, k=1..6) → FIFO holds k=1..4 and `drop_cnt`=2.
  - Then `m_ready`=1: outputs 1,2,3,4 in order, then `m_valid`=0.
- FIFO full, `m_ready`=1 and new sample same edge → head popped, new sample stored, `drop_cnt` unchanged, occupancy stays 4.
- `rst` pulsed low mid-stream with 3 entries queued → `m_valid`=0 immediately (asynchronous), counters 0; the next 7 `ena` cycles produce no writes.
